// File: rtl/sprite_mem_arbiter_if.sv
// Bundle between sprite fetch engines, the shared on_chip_mem read port and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding fabric (requesters + memory).
interface sprite_mem_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 8
) ();
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            gnt;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_data;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;
  logic                          busy;

  modport master (
    output req, lock, req_addr, mem_data,
    input  gnt, mem_addr, rvalid, rdata, busy
  );

  modport slave (
    input  req, lock, req_addr, mem_data,
    output gnt, mem_addr, rvalid, rdata, busy
  );
endinterface

// File: rtl/sprite_mem_arbiter.sv
// Round-robin arbiter (bounded lock bursts) sharing the on_chip_mem read port; routes data back by id.
// Grant is combinational; rvalid/rdata arrive MEM_LATENCY+1 cycles after gnt; no backpressure on return.
module sprite_mem_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 22,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_LATENCY = 2,
  parameter int MAX_BURST   = 8
) (
  input logic                clk,
  input logic                reset,
  sprite_mem_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  logic [IDW-1:0]        rr_ptr;
  logic [CW-1:0]         burst_cnt;
  logic [IDW-1:0]        owner;
  logic                  owner_vld;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [MEM_LATENCY-1:0] pipe_vld;
  logic [IDW-1:0]        pipe_id [MEM_LATENCY];
  logic [NUM_REQ-1:0]    rvalid_q;

  logic                  gnt_vld;
  logic [IDW-1:0]        gnt_id;
  logic [NUM_REQ-1:0]    gnt_oh;
  logic [IDW-1:0]        owner_nxt;
  logic                  owner_vld_nxt;
  logic [CW-1:0]         cnt_nxt;
  logic [CW-1:0]         cnt_n;
  logic [NUM_REQ-1:0]    rvalid_nxt;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // A locked owner keeps the port until it lets go or uses up its burst allowance.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    if (owner_vld && bus.req[owner] && bus.lock[owner] && (burst_cnt < CW'(MAX_BURST))) begin
      gnt_vld = 1'b1;
      gnt_id  = owner;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (bus.req[wrap_add(rr_ptr, k)]) begin
          gnt_vld = 1'b1;
          gnt_id  = wrap_add(rr_ptr, k);
        end
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (gnt_vld && !reset) gnt_oh[gnt_id] = 1'b1;
  end

  always_comb begin
    owner_nxt     = owner;
    owner_vld_nxt = owner_vld;
    cnt_nxt       = burst_cnt;
    cnt_n         = CW'(1);
    if (owner_vld && !(bus.req[owner] && bus.lock[owner])) begin
      owner_vld_nxt = 1'b0;
      cnt_nxt       = '0;
    end
    if (gnt_vld) begin
      if (bus.lock[gnt_id]) begin
        if (owner_vld && (owner == gnt_id)) cnt_n = burst_cnt + CW'(1);
        // Hitting the cap releases ownership so round robin moves past this requester.
        if (cnt_n >= CW'(MAX_BURST)) begin
          owner_vld_nxt = 1'b0;
          cnt_nxt       = '0;
        end else begin
          owner_vld_nxt = 1'b1;
          owner_nxt     = gnt_id;
          cnt_nxt       = cnt_n;
        end
      end else begin
        owner_vld_nxt = 1'b0;
        cnt_nxt       = CW'(1);
      end
    end
  end

  always_comb begin
    rvalid_nxt = '0;
    if (pipe_vld[MEM_LATENCY-1]) rvalid_nxt[pipe_id[MEM_LATENCY-1]] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      burst_cnt  <= '0;
      owner      <= '0;
      owner_vld  <= 1'b0;
      mem_addr_q <= '0;
      pipe_vld   <= '0;
      rvalid_q   <= '0;
      for (int s = 0; s < MEM_LATENCY; s++) pipe_id[s] <= '0;
    end else begin
      owner     <= owner_nxt;
      owner_vld <= owner_vld_nxt;
      burst_cnt <= cnt_nxt;
      if (gnt_vld) begin
        mem_addr_q <= addr_arr[gnt_id];
        rr_ptr     <= wrap_add(gnt_id, 1);
      end
      // Id pipe mirrors the memory latency so each return lands on its requester.
      pipe_vld[0] <= gnt_vld;
      pipe_id[0]  <= gnt_id;
      for (int s = 1; s < MEM_LATENCY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_id[s]  <= pipe_id[s-1];
      end
      rvalid_q <= rvalid_nxt;
    end
  end

  assign bus.gnt      = gnt_oh;
  assign bus.mem_addr = mem_addr_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = bus.mem_data;
  assign bus.busy     = |pipe_vld;
endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Directed vectors for sprite_mem_arbiter with a two-stage memory model (data = addr[7:0]).
module tb_sprite_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sprite_mem_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(22), .DATA_WIDTH(8)) bus ();

  sprite_mem_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(22), .DATA_WIDTH(8), .MEM_LATENCY(2), .MAX_BURST(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [7:0] mem_d1;
  always @(posedge clk) begin
    mem_d1       <= bus.mem_addr[7:0];
    bus.mem_data <= mem_d1;
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] nib;
    logic [3:0] gnt;
    logic [3:0] rv;
    logic [7:0] rd;
    logic       busy;
  } vec_t;

  vec_t       tbl [23];
  logic [3:0] bexp [15];

  function automatic logic [21:0] mk_addr(input int k, input logic [3:0] n);
    return {10'h155, 4'(k), 4'(k), n};
  endfunction

  function automatic int oh2id(input logic [3:0] oh);
    int id;
    id = 0;
    for (int k = 0; k < 4; k++) if (oh[k]) id = k;
    return id;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [3:0] n);
    bus.req  = r;
    bus.lock = l;
    for (int k = 0; k < 4; k++) bus.req_addr[k*22 +: 22] = mk_addr(k, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    //           req      lock  nib   gnt      rvalid   rdata  busy
    tbl[0]  = '{4'b0010, 4'b0, 4'h5, 4'b0010, 4'b0000, 8'h00, 1'b0};
    tbl[1]  = '{4'b0000, 4'b0, 4'h0, 4'b0000, 4'b0000, 8'h00, 1'b1};
    tbl[2]  = '{4'b0000, 4'b0, 4'h0, 4'b0000, 4'b0000, 8'h00, 1'b1};
    tbl[3]  = '{4'b0000, 4'b0, 4'h0, 4'b0000, 4'b0010, 8'h15, 1'b0};
    tbl[4]  = '{4'b1111, 4'b0, 4'h4, 4'b0100, 4'b0000, 8'h00, 1'b0};
    tbl[5]  = '{4'b1111, 4'b0, 4'h5, 4'b1000, 4'b0000, 8'h00, 1'b1};
    tbl[6]  = '{4'b1111, 4'b0, 4'h6, 4'b0001, 4'b0000, 8'h00, 1'b1};
    tbl[7]  = '{4'b1111, 4'b0, 4'h7, 4'b0010, 4'b0100, 8'h24, 1'b1};
    tbl[8]  = '{4'b1111, 4'b0, 4'h8, 4'b0100, 4'b1000, 8'h35, 1'b1};
    tbl[9]  = '{4'b1111, 4'b0, 4'h9, 4'b1000, 4'b0001, 8'h06, 1'b1};
    tbl[10] = '{4'b1111, 4'b0, 4'hA, 4'b0001, 4'b0010, 8'h17, 1'b1};
    tbl[11] = '{4'b1111, 4'b0, 4'hB, 4'b0010, 4'b0100, 8'h28, 1'b1};
    tbl[12] = '{4'b0000, 4'b0, 4'h0, 4'b0000, 4'b1000, 8'h39, 1'b1};
    tbl[13] = '{4'b0000, 4'b0, 4'h0, 4'b0000, 4'b0001, 8'h0A, 1'b1};
    tbl[14] = '{4'b0000, 4'b0, 4'h0, 4'b0000, 4'b0010, 8'h1B, 1'b0};
    tbl[15] = '{4'b0000, 4'b0, 4'h0, 4'b0000, 4'b0000, 8'h00, 1'b0};
    tbl[16] = '{4'b0100, 4'b0, 4'hC, 4'b0100, 4'b0000, 8'h00, 1'b0};
    tbl[17] = '{4'b1001, 4'b0, 4'hD, 4'b1000, 4'b0000, 8'h00, 1'b1};
    tbl[18] = '{4'b1001, 4'b0, 4'hE, 4'b0001, 4'b0000, 8'h00, 1'b1};
    tbl[19] = '{4'b0000, 4'b0, 4'h0, 4'b0000, 4'b0100, 8'h2C, 1'b1};
    tbl[20] = '{4'b0000, 4'b0, 4'h0, 4'b0000, 4'b1000, 8'h3D, 1'b1};
    tbl[21] = '{4'b0000, 4'b0, 4'h0, 4'b0000, 4'b0001, 8'h0E, 1'b0};
    tbl[22] = '{4'b0000, 4'b0, 4'h0, 4'b0000, 4'b0000, 8'h00, 1'b0};

    bexp = '{4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
             4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0010};

    // Reset state, with every requester asking.
    drive(4'b1111, 4'b0000, 4'h0);
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(4'b0000, 4'b0000, 4'h0);

    for (int i = 0; i < 23; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].req, tbl[i].lock, tbl[i].nib);
      @(negedge clk);
      chk($sformatf("row%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
      chk($sformatf("row%0d_rvalid", i), 32'(bus.rvalid), 32'(tbl[i].rv));
      chk($sformatf("row%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      if (tbl[i].rv != 4'b0000)
        chk($sformatf("row%0d_rdata", i), 32'(bus.rdata), 32'(tbl[i].rd));
      if (i > 0 && tbl[i-1].gnt != 4'b0000)
        chk($sformatf("row%0d_mem_addr", i), 32'(bus.mem_addr),
            32'(mk_addr(oh2id(tbl[i-1].gnt), tbl[i-1].nib)));
    end

    // Burst: req0 locked against req1, cap at 8, then lock dropped.
    for (int c = 0; c < 18; c++) begin
      logic [3:0] eg, erv;
      eg  = (c < 15) ? bexp[c] : 4'b0000;
      erv = (c >= 3 && c < 18) ? bexp[c-3] : 4'b0000;
      @(posedge clk); #1;
      drive((c < 15) ? 4'b0011 : 4'b0000, (c < 12) ? 4'b0001 : 4'b0000, 4'(c));
      @(negedge clk);
      chk($sformatf("burst%0d_gnt", c), 32'(bus.gnt), 32'(eg));
      chk($sformatf("burst%0d_rvalid", c), 32'(bus.rvalid), 32'(erv));
      if (erv != 4'b0000)
        chk($sformatf("burst%0d_rdata", c), 32'(bus.rdata), 32'({4'(oh2id(erv)), 4'(c - 3)}));
    end

    // Reset with two reads in flight: they must never return.
    @(posedge clk); #1;
    drive(4'b0001, 4'b0000, 4'h1);
    @(negedge clk);
    chk("pre_rst_gnt0", 32'(bus.gnt), 32'h1);
    @(posedge clk); #1;
    drive(4'b0010, 4'b0000, 4'h2);
    @(negedge clk);
    chk("pre_rst_gnt1", 32'(bus.gnt), 32'h2);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(4'b1111, 4'b0000, 4'h3);
    @(negedge clk);
    chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("mid_rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(4'b0100, 4'b0000, 4'h4);
    @(negedge clk);
    chk("post_rst_gnt", 32'(bus.gnt), 32'h4);
    chk("post_rst_rvalid0", 32'(bus.rvalid), 32'h0);
    chk("post_rst_busy0", 32'(bus.busy), 32'h0);
    for (int e = 1; e < 4; e++) begin
      @(posedge clk); #1;
      drive(4'b0000, 4'b0000, 4'h0);
      @(negedge clk);
      chk($sformatf("post_rst%0d_rvalid", e), 32'(bus.rvalid), (e == 3) ? 32'h4 : 32'h0);
      chk($sformatf("post_rst%0d_busy", e), 32'(bus.busy), (e == 3) ? 32'h0 : 32'h1);
      chk($sformatf("post_rst%0d_gnt", e), 32'(bus.gnt), 32'h0);
      if (e == 3) chk("post_rst_rdata", 32'(bus.rdata), 32'h24);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
